memory_responder: RTL and testbench

Word-addressed memory responder servicing the processor datapath's memory port. It captures the datapath's address and store data together with a read or write strobe, and inserts a configurable number of wait states. It then performs the access on an internal synchronous RAM and returns load data with a single-cycle ready pulse. It is the slave end of the datapath memory interface and replaces the ideal zero-latency memory model in system benches.

---
 rtl/memory_responder.sv | 151 +++++++++++++++
 tb/tb_memory_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Word-addressed memory responder: latches a read/write request, waits WAIT_CYCLES, accesses a synchronous RAM, pulses oReady.
// Optional feature: define MEMRESP_RANGE_CHECK_EN to fault and suppress accesses above the RAM's address range.
module memory_responder #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [31:0] iMemAddr,
   input  logic [31:0] iMemData,
   input  logic        iRead,
   input  logic        iWrite,
   output logic [31:0] oMemData,
   output logic        oReady,
   output logic        oBusy,
   output logic        oFault
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic              is_write_q, is_write_d;
   logic              fault_q, fault_d;
   logic              rd_valid_q, rd_valid_d;

   logic [31:0]       ram [2**ADDR_W];
   logic [31:0]       ram_rd_q;

   logic              req_start;
   logic              access;
   logic              ram_we;
   logic              ram_re;
   logic              oob_fault;
   logic              lat_oob;
   logic              unused_addr_bits;

   assign req_start = (state_q == IDLE) && (iRead ^ iWrite);
   assign access    = (state_q == WAIT) && (cnt_q == 4'd0);
   assign ram_we    = access && is_write_q && !lat_oob;
   assign ram_re    = access && !is_write_q && !lat_oob;

`ifdef MEMRESP_RANGE_CHECK_EN
   logic oob_q, oob_d;

   assign oob_fault        = req_start && (|iMemAddr[31:ADDR_W+2]);
   assign lat_oob          = oob_q;
   assign unused_addr_bits = ^iMemAddr[1:0];

   always_comb begin
      oob_d = oob_q;
      if (req_start) begin
         oob_d = |iMemAddr[31:ADDR_W+2];
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oob_q <= 1'b0;
      end else begin
         oob_q <= oob_d;
      end
   end
`else
   // Upper address bits simply alias onto the RAM.
   assign oob_fault        = 1'b0;
   assign lat_oob          = 1'b0;
   assign unused_addr_bits = ^{iMemAddr[31:ADDR_W+2], iMemAddr[1:0]};
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      is_write_d = is_write_q;
      fault_d    = fault_q;
      rd_valid_d = rd_valid_q;
      case (state_q)
         IDLE: begin
            if (iRead && iWrite) begin
               fault_d = 1'b1;
            end else if (req_start) begin
               addr_d     = iMemAddr[ADDR_W+1:2];
               data_d     = iMemData;
               is_write_d = iWrite;
               cnt_d      = 4'(WAIT_CYCLES);
               state_d    = WAIT;
               if (oob_fault) begin
                  fault_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               // An out-of-range read masks the output to zero.
               if (!is_write_q) begin
                  rd_valid_d = !lat_oob;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         data_q     <= 32'd0;
         is_write_q <= 1'b0;
         fault_q    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         is_write_q <= is_write_d;
         fault_q    <= fault_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // RAM is never reset; the read register is qualified by rd_valid_q instead.
   always_ff @(posedge iClk) begin
      if (ram_we) begin
         ram[addr_q] <= data_q;
      end
      if (ram_re) begin
         ram_rd_q <= ram[addr_q];
      end
   end

   assign oMemData = rd_valid_q ? ram_rd_q : 32'd0;
   assign oReady   = (state_q == DONE);
   assign oBusy    = (state_q != IDLE);
   assign oFault   = fault_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: four instances with WAIT_CYCLES 2, 0, 1 and 15 on a shared clock and reset.
module tb_memory_responder;

   localparam int NI = 4;
   localparam int WC [NI] = '{2, 0, 1, 15};

   logic        clk;
   logic        rst;
   logic [31:0] addr  [NI];
   logic [31:0] wdata [NI];
   logic        rd    [NI];
   logic        wr    [NI];
   logic [31:0] mdata [NI];
   logic        rdy   [NI];
   logic        busy  [NI];
   logic        fault [NI];

   int errors = 0;
   int checks = 0;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      memory_responder #(
         .ADDR_W      (9),
         .WAIT_CYCLES (WC[gi])
      ) u_dut (
         .iClk     (clk),
         .iRst     (rst),
         .iMemAddr (addr[gi]),
         .iMemData (wdata[gi]),
         .iRead    (rd[gi]),
         .iWrite   (wr[gi]),
         .oMemData (mdata[gi]),
         .oReady   (rdy[gi]),
         .oBusy    (busy[gi]),
         .oFault   (fault[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that leaves DONE.
   task automatic txn(input int i, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input string tag, output logic [31:0] rdv);
      int e;
      int bc;
      rd[i] = r;
      wr[i] = w;
      addr[i] = a;
      wdata[i] = d;
      @(posedge clk); #1;
      e = 0;
      bc = 0;
      while (rdy[i] !== 1'b1 && e < 40) begin
         if (busy[i] === 1'b1) bc++;
         @(posedge clk); #1;
         e++;
      end
      if (busy[i] === 1'b1) bc++;
      rdv = mdata[i];
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      $display("txn %s inst=%0d rd=%0b wr=%0b addr=%h wdata=%h edges=%0d busy=%0d rdata=%h",
               tag, i, r, w, a, d, e, bc, rdv);
      check({tag, " latency"}, 32'(e), 32'(WC[i] + 1));
      check({tag, " busy_cycles"}, 32'(bc), 32'(WC[i] + 2));
      @(posedge clk); #1;
      check({tag, " pulse_end"}, 32'({rdy[i], busy[i]}), 32'd0);
      check({tag, " data_hold"}, mdata[i], rdv);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int          seen;
      logic        exp_r;

      vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0010, data: 32'hDEAD_BEEF, exp_data: 32'h0000_0000};
      vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0010, data: 32'h0000_0000, exp_data: 32'hDEAD_BEEF};
      vecs[2] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0008, data: 32'h1111_1111, exp_data: 32'hDEAD_BEEF};
      vecs[3] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_07FC, data: 32'hCAFE_F00D, exp_data: 32'hDEAD_BEEF};
      vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0008, data: 32'h0000_0000, exp_data: 32'h1111_1111};
      vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_07FC, data: 32'h0000_0000, exp_data: 32'hCAFE_F00D};
      vecs[6] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0013, data: 32'h0BAD_F00D, exp_data: 32'hCAFE_F00D};
      vecs[7] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0010, data: 32'h0000_0000, exp_data: 32'h0BAD_F00D};

      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         rd[i] = 1'b0;
         wr[i] = 1'b0;
         addr[i] = 32'd0;
         wdata[i] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset mdata inst%0d", i), mdata[i], 32'd0);
         check($sformatf("reset flags inst%0d", i), 32'({rdy[i], busy[i], fault[i]}), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Main table on the WAIT_CYCLES=2 instance.
      for (int k = 0; k < 8; k++) begin
         txn(0, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].data, $sformatf("vec%0d", k), got);
         check($sformatf("vec%0d mdata", k), got, vecs[k].exp_data);
         check($sformatf("vec%0d fault", k), 32'(fault[0]), 32'd0);
      end

      // Latency sweep on the other instances.
      for (int i = 1; i < NI; i++) begin
         txn(i, 1'b0, 1'b1, 32'h0000_0040, 32'h600D_0000 + 32'(i), $sformatf("sweep_wr%0d", i), got);
         txn(i, 1'b1, 1'b0, 32'h0000_0040, 32'd0, $sformatf("sweep_rd%0d", i), got);
         check($sformatf("sweep_rd%0d mdata", i), got, 32'h600D_0000 + 32'(i));
      end

      // Read/write conflict.
      rd[0] = 1'b1;
      wr[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check($sformatf("conflict%0d rdy_busy", c), 32'({rdy[0], busy[0]}), 32'd0);
         check($sformatf("conflict%0d fault", c), 32'(fault[0]), 32'd1);
      end
      rd[0] = 1'b0;
      wr[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("conflict sticky fault", 32'(fault[0]), 32'd1);
      $display("txn conflict inst=0 fault=%0b", fault[0]);
      rst = 1'b1;
      #1;
      check("conflict fault cleared", 32'(fault[0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Out-of-range address 0x1000 with ADDR_W=9.
      txn(0, 1'b0, 1'b1, 32'h0000_0000, 32'h55AA_55AA, "oob_pre", got);
      txn(0, 1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, "oob_wr", got);
      txn(0, 1'b1, 1'b0, 32'h0000_1000, 32'd0, "oob_rd", got);
`ifdef MEMRESP_RANGE_CHECK_EN
      check("oob_rd mdata", got, 32'd0);
      check("oob fault", 32'(fault[0]), 32'd1);
      txn(0, 1'b1, 1'b0, 32'h0000_0000, 32'd0, "oob_rd0", got);
      check("oob_rd0 mdata", got, 32'h55AA_55AA);
`else
      check("oob_rd mdata", got, 32'h1234_5678);
      check("oob fault", 32'(fault[0]), 32'd0);
      txn(0, 1'b1, 1'b0, 32'h0000_0000, 32'd0, "oob_rd0", got);
      check("oob_rd0 mdata", got, 32'h1234_5678);
`endif

      // Reset asserted while cnt=1 aborts a pending write.
      txn(0, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, "abort_pre", got);
      wr[0] = 1'b1;
      addr[0] = 32'h0000_0008;
      wdata[0] = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort busy before reset", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      wr[0] = 1'b0;
      #1;
      check("abort mdata", mdata[0], 32'd0);
      check("abort flags", 32'({rdy[0], busy[0], fault[0]}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (rdy[0] === 1'b1) seen++;
      end
      check("abort no ready", 32'(seen), 32'd0);
      $display("txn abort inst=0 ready_after_reset=%0d", seen);
      txn(0, 1'b1, 1'b0, 32'h0000_0008, 32'd0, "abort_rd", got);
      check("abort_rd mdata", got, 32'h1111_1111);

      // Held read strobe on the WAIT_CYCLES=1 instance, address changed mid-transaction.
      txn(2, 1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_0001, "held_pre0", got);
      txn(2, 1'b0, 1'b1, 32'h0000_0024, 32'hBBBB_0002, "held_pre1", got);
      rd[2] = 1'b1;
      addr[2] = 32'h0000_0020;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (k == 1) addr[2] = 32'h0000_0024;
         if (k == 5) addr[2] = 32'h0000_0020;
         exp_r = (k == 3) || (k == 7) || (k == 11);
         check($sformatf("held edge%0d ready", k), 32'(rdy[2]), 32'(exp_r));
         if (exp_r) begin
            check($sformatf("held edge%0d mdata", k), mdata[2],
                  (k == 7) ? 32'hBBBB_0002 : 32'hAAAA_0001);
            $display("txn held inst=2 edge=%0d rdata=%h", k, mdata[2]);
         end
         if (k == 11) rd[2] = 1'b0;
      end
      @(posedge clk); #1;
      check("held idle after release", 32'({rdy[2], busy[2]}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
